shift_unit_seq: RTL and testbench
=================================

// Module: shift_unit_seq
// PURPOSE
//  Sequential shifter that consumes the 5-bit shift amount produced by the
//  shift-amount select mux. Operand comes from Reg A/B; the datapath FSM
//  drives the op code.
//  - Shifts by one bit per cycle under a start/busy/done handshake.
//  - Holds the result until the next accepted start, for write-back to the
//    register file.
// PARAMETERS
//  DATA_W   32  operand/result width
//  AMT_W    5   shift-amount width; must equal clog2(DATA_W)
// PORTS
//  clk      in   1        single clock, rising edge
//  reset    in   1        asynchronous, active-low (0 = reset)
//  start    in   1        request; sampled only in IDLE
//  op       in   3        shift operation (encoding in package)
//  data_in  in   DATA_W   operand, captured on the accepting edge
//  shamt    in   AMT_W    shift amount from the shift-amount mux, captured on the accepting edge
//  busy     out  1        high in SHIFT and DONE
//  done     out  1        one-cycle pulse; result valid
//  result   out  DATA_W   shifted value, held stable until the next accept
// BEHAVIOUR
//  Reset (async, reset==0): state=IDLE; busy=0, done=0, result=0, cnt=0.
//  FSM states:
//   - IDLE: start=1 latches op, data_in into acc, shamt into cnt.
//     cnt==0 or illegal op -> DONE; otherwise -> SHIFT.
//   - SHIFT: each edge applies a 1-bit step to acc and decrements cnt.
//     The step taken at cnt==1 moves the FSM to DONE.
//   - DONE: done=1 for exactly one cycle; result=acc; next state IDLE.
//     A start in DONE is ignored.
//  Latency: done goes high N+1 cycles after the accepting edge (N = shamt).
//   - N=0: done is high in the cycle right after acceptance.
//   - Maximum N=31: 32 cycles.
//  Op encoding:
//   - 000 SLL: zero-fill from the LSB.
//   - 001 SRL: zero-fill from the MSB.
//   - 010 SRA: MSB replicated.
//   - 011 ROR: bit0 moves to the MSB.
//   - 100 ROL: MSB moves to bit0.
//   - 101..111 illegal: pass-through, data unchanged, takes the N=0 timing.
//  Arithmetic/width rules:
//   - Only shamt[AMT_W-1:0] is used; no shift of DATA_W or more is possible.
//   - SRA by 31 gives all sign bits.
//  Boundary conditions:
//   - start while busy: ignored, no queueing; inputs may change freely.
//   - Inputs are don't-care outside the accepting edge.
//   - Reset mid-SHIFT: operation aborted; outputs return to reset values
//     asynchronously; no done pulse.
//   - start held high: a new operation is accepted each time the FSM
//     reaches IDLE (back-to-back ops).
// CONFIGURATION
//  FAST_SHIFT_EN defined:
//   - Combinational barrel shifter; SHIFT state removed.
//   - Accept -> DONE on the next edge for every op/amount.
//   - done comes 1 cycle after accept; busy is high only in DONE.
//  FAST_SHIFT_EN undefined: iterative 1-bit/cycle behaviour above.
//  Handshake and result values are identical in both builds; only latency
//  differs.
// STRUCTURE
//  Package shift_pkg:
//   - op localparams SH_SLL, SH_SRL, SH_SRA, SH_ROR, SH_ROL.
//   - state encodings S_IDLE, S_SHIFT, S_DONE.
//   - DATA_W/AMT_W defaults.
//  Sub-module shift_step (combinational):
//   - Inputs: op, acc, and a step amount (1 iterative, shamt in fast build).
//   - Output: the shifted value.
//   - Shared by both builds so the op semantics exist once.
// TESTING
//  1. SLL data=0x0000_0001 shamt=4 -> done 5 cycles after accept,
//     result=0x0000_0010, busy high 5 cycles.
//  2. SRA data=0x8000_0000 shamt=31 -> result=0xFFFF_FFFF after 32 cycles;
//     SRL same inputs -> 0x0000_0001.
//  3. ROR data=0x0000_0003 shamt=1 -> 0x8000_0001; ROL data=0x8000_0000
//     shamt=1 -> 0x0000_0001.
//  4. shamt=0 or op=3'b111 data=0xDEAD_BEEF -> done 1 cycle after accept,
//     result=0xDEAD_BEEF.
//  5. start re-pulsed while busy with a different operand -> ignored; first
//     result is unchanged and exactly one done pulse occurs.
//  6. reset low mid-SHIFT (after 3 of 8 steps) -> busy/done/result=0
//     immediately; no done pulse; a new op after release is correct.
//     Rerun all cases with FAST_SHIFT_EN: latency is always 1.

Source files
------------

// File: rtl/shift_unit_seq_pkg.sv
// Shared types and constants for the sequential shifter: op codes, FSM states,
// default widths and a legality helper for op codes.
package shift_pkg;

   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned AMT_W_DEF  = 5;

   localparam logic [2:0] SH_SLL = 3'b000;
   localparam logic [2:0] SH_SRL = 3'b001;
   localparam logic [2:0] SH_SRA = 3'b010;
   localparam logic [2:0] SH_ROR = 3'b011;
   localparam logic [2:0] SH_ROL = 3'b100;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   function automatic logic op_legal(input logic [2:0] op);
      return (op <= SH_ROL);
   endfunction

endpackage

// File: rtl/shift_unit_seq_if.sv
// Start/busy/done handshake plus operand and result bus of the shifter.
interface shift_unit_seq_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned AMT_W  = 5
);
   logic              start;
   logic [2:0]        op;
   logic [DATA_W-1:0] data_in;
   logic [AMT_W-1:0]  shamt;
   logic              busy;
   logic              done;
   logic [DATA_W-1:0] result;

   modport master (output start, op, data_in, shamt, input busy, done, result);
   modport slave  (input start, op, data_in, shamt, output busy, done, result);
endinterface

// File: rtl/shift_unit_seq_step.sv
// Combinational shift/rotate by a variable amount; the single place where op
// semantics live, used with amt=1 iteratively or full shamt in the fast build.
module shift_step
   import shift_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned AMT_W  = AMT_W_DEF
) (
   input  logic [2:0]        op,
   input  logic [DATA_W-1:0] acc,
   input  logic [AMT_W-1:0]  amt,
   output logic [DATA_W-1:0] res
);

   logic [2*DATA_W-1:0] dbl_r;
   logic [2*DATA_W-1:0] dbl_l;

   // Rotates come from shifting a doubled copy and taking the relevant half.
   always_comb begin
      dbl_r = {acc, acc} >> amt;
      dbl_l = {acc, acc} << amt;
      case (op)
         SH_SLL:  res = acc << amt;
         SH_SRL:  res = acc >> amt;
         SH_SRA:  res = $unsigned($signed(acc) >>> amt);
         SH_ROR:  res = dbl_r[DATA_W-1:0];
         SH_ROL:  res = dbl_l[2*DATA_W-1:DATA_W];
         default: res = acc;
      endcase
   end

endmodule

// File: rtl/shift_unit_seq.sv
// Sequential shifter with start/busy/done handshake; result held until the
// next completed op. Define FAST_SHIFT_EN for a single-cycle barrel build.
module shift_unit_seq
   import shift_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned AMT_W  = AMT_W_DEF
) (
   input logic             clk,
   input logic             reset,
   shift_unit_seq_if.slave bus
);

   state_t            state_q, state_d;
   logic [2:0]        op_q, op_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [AMT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] result_q, result_d;

   logic [2:0]        step_op;
   logic [DATA_W-1:0] step_acc;
   logic [AMT_W-1:0]  step_amt;
   logic [DATA_W-1:0] step_res;

   shift_step #(.DATA_W(DATA_W), .AMT_W(AMT_W)) u_step (
      .op  (step_op),
      .acc (step_acc),
      .amt (step_amt),
      .res (step_res)
   );

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      result_d = result_q;
`ifdef FAST_SHIFT_EN
      step_op  = bus.op;
      step_acc = bus.data_in;
      step_amt = bus.shamt;
`else
      step_op  = op_q;
      step_acc = acc_q;
      step_amt = AMT_W'(1);
`endif
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               op_d  = bus.op;
               cnt_d = bus.shamt;
`ifdef FAST_SHIFT_EN
               acc_d    = step_res;
               result_d = step_res;
               state_d  = S_DONE;
`else
               acc_d = bus.data_in;
               if (bus.shamt == '0 || !op_legal(bus.op)) begin
                  result_d = bus.data_in;
                  state_d  = S_DONE;
               end else begin
                  state_d = S_SHIFT;
               end
`endif
            end
         end
`ifndef FAST_SHIFT_EN
         S_SHIFT: begin
            acc_d = step_res;
            cnt_d = cnt_q - AMT_W'(1);
            // Result is published on the same edge as the final step so it is valid with done.
            if (cnt_q == AMT_W'(1)) begin
               result_d = step_res;
               state_d  = S_DONE;
            end
         end
`endif
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
      end
   end

   assign bus.busy   = (state_q != S_IDLE);
   assign bus.done   = (state_q == S_DONE);
   assign bus.result = result_q;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Self-checking bench for shift_unit_seq: directed cases plus random ops
// against an arithmetic reference model; handles both latency builds.
module tb_shift_unit_seq;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   shift_unit_seq_if #(.DATA_W(32), .AMT_W(5)) bus ();

   shift_unit_seq #(.DATA_W(32), .AMT_W(5)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Shift semantics expressed as multiplication/division by powers of two.
   function automatic logic [31:0] ref_shift(input logic [2:0] op, input logic [31:0] d, input int n);
      longint unsigned x, p, q, nd;
      x  = {32'b0, d};
      p  = 64'd1 << n;
      q  = 64'd1 << (32 - n);
      nd = {32'b0, ~d};
      case (op)
         3'd0:    return 32'(x * p);
         3'd1:    return 32'(x / p);
         3'd2:    return d[31] ? ~32'(nd / p) : 32'(x / p);
         3'd3:    return 32'(x / p) | 32'(x * q);
         3'd4:    return 32'(x * p) | 32'(x / q);
         default: return d;
      endcase
   endfunction

   function automatic int exp_lat(input logic [2:0] op, input int n);
`ifdef FAST_SHIFT_EN
      return 0;
`else
      return (op <= 3'd4 && n != 0) ? n : 0;
`endif
   endfunction

   // Drive one op from IDLE; latency counted in edges after the accepting edge.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] d,
                         input int n, input bit interfere, input logic [31:0] exp);
      int k;
      bit busy_ok;
      busy_ok     = 1'b1;
      bus.start   = 1'b1;
      bus.op      = op;
      bus.data_in = d;
      bus.shamt   = 5'(n);
      @(posedge clk); #1;
      bus.start   = interfere;
      bus.op      = 3'($urandom);
      bus.data_in = $urandom;
      bus.shamt   = 5'($urandom);
      k = 0;
      while (!bus.done && k < 40) begin
         if (!bus.busy) busy_ok = 1'b0;
         @(posedge clk); #1;
         k++;
         if (interfere) begin
            bus.data_in = $urandom;
            bus.shamt   = 5'($urandom);
         end
      end
      chk({tag, "_lat"}, 64'(k), 64'(exp_lat(op, n)));
      chk({tag, "_busy"}, {63'b0, busy_ok & bus.busy}, 64'd1);
      chk({tag, "_res"}, {32'b0, bus.result}, {32'b0, exp});
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk({tag, "_pulse"}, {62'b0, bus.busy, bus.done}, 64'd0);
      chk({tag, "_hold"}, {32'b0, bus.result}, {32'b0, exp});
      if (interfere) begin
         @(posedge clk); #1;
         chk({tag, "_nodup"}, {62'b0, bus.busy, bus.done}, 64'd0);
      end
   endtask

   logic [2:0]  r_op;
   logic [31:0] r_d;
   int          r_n;
   bit          saw_done;

   initial begin
      n_checks    = 0;
      n_fail      = 0;
      reset       = 1'b0;
      bus.start   = 1'b0;
      bus.op      = '0;
      bus.data_in = '0;
      bus.shamt   = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", {63'b0, bus.busy}, 64'd0);
      chk("rst_done", {63'b0, bus.done}, 64'd0);
      chk("rst_res", {32'b0, bus.result}, 64'd0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;

      run_op("sll4",   3'd0, 32'h0000_0001, 4,  1'b0, 32'h0000_0010);
      run_op("sra31",  3'd2, 32'h8000_0000, 31, 1'b0, 32'hFFFF_FFFF);
      run_op("srl31",  3'd1, 32'h8000_0000, 31, 1'b0, 32'h0000_0001);
      run_op("ror1",   3'd3, 32'h0000_0003, 1,  1'b0, 32'h8000_0001);
      run_op("rol1",   3'd4, 32'h8000_0000, 1,  1'b0, 32'h0000_0001);
      run_op("n0",     3'd0, 32'hDEAD_BEEF, 0,  1'b0, 32'hDEAD_BEEF);
      run_op("ill7",   3'd7, 32'hDEAD_BEEF, 9,  1'b0, 32'hDEAD_BEEF);
      run_op("ill5",   3'd5, 32'h1234_5678, 3,  1'b0, 32'h1234_5678);
      run_op("intf",   3'd1, 32'hF000_0000, 6,  1'b1, 32'h03C0_0000);

      // Reset asserted partway through an 8-step shift.
      bus.start   = 1'b1;
      bus.op      = 3'd0;
      bus.data_in = 32'h0000_00FF;
      bus.shamt   = 5'd8;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      chk("mid_rst_busy", {63'b0, bus.busy}, 64'd0);
      chk("mid_rst_done", {63'b0, bus.done}, 64'd0);
      chk("mid_rst_res", {32'b0, bus.result}, 64'd0);
      saw_done = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         if (bus.done) saw_done = 1'b1;
      end
      chk("mid_rst_nodone", {63'b0, saw_done}, 64'd0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      run_op("post_rst", 3'd4, 32'hF000_000F, 8, 1'b0, 32'h0000_0FF0);

      for (int i = 0; i < 40; i++) begin
         r_op = 3'($urandom_range(0, 7));
         r_d  = $urandom;
         r_n  = (i < 4) ? ((i % 2 == 0) ? 0 : 31) : int'($urandom_range(0, 31));
         run_op($sformatf("rnd%0d", i), r_op, r_d, r_n, 1'($urandom_range(0, 1)),
                ref_shift(r_op, r_d, r_n));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
